// File: rtl/hdmi_rd_pkg.sv
// FSM encoding and frame-geometry helpers shared by the HDMI frame read-address generator.
package hdmi_rd_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned ST_W   = 3;

  localparam logic [ST_W-1:0] ST_IDLE       = 3'd0;
  localparam logic [ST_W-1:0] ST_ISSUE_IDLE = 3'd1;
  localparam logic [ST_W-1:0] ST_ISSUE      = 3'd2;
  localparam logic [ST_W-1:0] ST_ISSUE_WAIT = 3'd3;
  localparam logic [ST_W-1:0] ST_NEXT_IDLE  = 3'd4;

  function automatic int unsigned fs_w(input int unsigned num_frames);
    return (num_frames <= 32'd1) ? 32'd1 : 32'($clog2(num_frames));
  endfunction

  function automatic int unsigned bursts_per_line(input int unsigned x_size,
                                                  input int unsigned burst_words);
    return x_size / burst_words;
  endfunction

  function automatic int unsigned bursts_per_frame(input int unsigned x_size,
                                                   input int unsigned y_size,
                                                   input int unsigned burst_words);
    return (x_size * y_size) / burst_words;
  endfunction

  function automatic int unsigned burst_bytes(input int unsigned burst_words,
                                              input int unsigned bytes_per_pixel);
    return burst_words * bytes_per_pixel;
  endfunction

endpackage

// File: rtl/hdmi_rd_offset_cnt.sv
// Byte-offset walker for one frame: a linear burst counter by default, or a
// line/burst-in-line pair with a line pitch when HDMI_RD_LINE_PITCH_EN is defined.
module hdmi_rd_offset_cnt
  import hdmi_rd_pkg::*;
#(
  parameter int unsigned X_SIZE          = 256,
  parameter int unsigned Y_SIZE          = 256,
  parameter int unsigned BYTES_PER_PIXEL = 4,
  parameter int unsigned BURST_WORDS     = 256
`ifdef HDMI_RD_LINE_PITCH_EN
  ,
  parameter int unsigned LINE_PITCH      = X_SIZE * BYTES_PER_PIXEL
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] offset,
  output logic              last
);

  localparam int unsigned BURST_BYTES = burst_bytes(BURST_WORDS, BYTES_PER_PIXEL);

  logic [ADDR_W-1:0] offset_q, offset_d;
  logic              last_q, last_d;

`ifdef HDMI_RD_LINE_PITCH_EN
  localparam int unsigned BURSTS_PER_LINE = bursts_per_line(X_SIZE, BURST_WORDS);
  localparam logic        LAST_AT_CLEAR   = (BURSTS_PER_LINE == 1) && (Y_SIZE == 1);

  logic [31:0]       bil_q, bil_d;
  logic [31:0]       line_q, line_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;

  // Offset is accumulated, so no multiplier sits in the address path.
  always_comb begin
    bil_d       = bil_q;
    line_d      = line_q;
    line_base_d = line_base_q;
    offset_d    = offset_q;
    last_d      = last_q;
    if (clear) begin
      bil_d       = '0;
      line_d      = '0;
      line_base_d = '0;
      offset_d    = '0;
      last_d      = LAST_AT_CLEAR;
    end else if (advance) begin
      if (bil_q == 32'(BURSTS_PER_LINE - 1)) begin
        bil_d = '0;
        if (line_q == 32'(Y_SIZE - 1)) begin
          line_d      = '0;
          line_base_d = '0;
        end else begin
          line_d      = line_q + 32'd1;
          line_base_d = line_base_q + 32'(LINE_PITCH);
        end
        offset_d = line_base_d;
      end else begin
        bil_d    = bil_q + 32'd1;
        offset_d = offset_q + 32'(BURST_BYTES);
      end
      last_d = (bil_d == 32'(BURSTS_PER_LINE - 1)) && (line_d == 32'(Y_SIZE - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bil_q       <= '0;
      line_q      <= '0;
      line_base_q <= '0;
      offset_q    <= '0;
      last_q      <= LAST_AT_CLEAR;
    end else begin
      bil_q       <= bil_d;
      line_q      <= line_d;
      line_base_q <= line_base_d;
      offset_q    <= offset_d;
      last_q      <= last_d;
    end
  end
`else
  localparam int unsigned BURSTS_PER_FRAME = bursts_per_frame(X_SIZE, Y_SIZE, BURST_WORDS);
  localparam logic        LAST_AT_CLEAR    = (BURSTS_PER_FRAME == 1);

  logic [31:0] idx_q, idx_d;

  always_comb begin
    idx_d    = idx_q;
    offset_d = offset_q;
    last_d   = last_q;
    if (clear || (advance && last_q)) begin
      idx_d    = '0;
      offset_d = '0;
      last_d   = LAST_AT_CLEAR;
    end else if (advance) begin
      idx_d    = idx_q + 32'd1;
      offset_d = offset_q + 32'(BURST_BYTES);
      last_d   = (idx_d == 32'(BURSTS_PER_FRAME - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      offset_q <= '0;
      last_q   <= LAST_AT_CLEAR;
    end else begin
      idx_q    <= idx_d;
      offset_q <= offset_d;
      last_q   <= last_d;
    end
  end
`endif

  assign offset = offset_q;
  assign last   = last_q;

endmodule

// File: rtl/hdmi_frame_rd_addr.sv
// Frame read-address generator: walks one ring buffer in fixed AXI bursts, throttled by FIFO fill.
// Optional line-pitch addressing is enabled by defining HDMI_RD_LINE_PITCH_EN.
module hdmi_frame_rd_addr
  import hdmi_rd_pkg::*;
#(
  parameter int unsigned X_SIZE          = 256,
  parameter int unsigned Y_SIZE          = 256,
  parameter int unsigned BYTES_PER_PIXEL = 4,
  parameter int unsigned BURST_WORDS     = 256,
  parameter int unsigned NUM_FRAMES      = 2,
  parameter logic [31:0] BASE_ADDR       = 32'h0,
  parameter logic [31:0] FRAME_STRIDE    = 32'h200_0000,
  parameter int unsigned LINE_PITCH      = X_SIZE * BYTES_PER_PIXEL,
  parameter int unsigned FIFO_LOW_WM     = 6400
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        prefetch_line,
  input  logic [31:0]                 fifo_available,
  input  logic [fs_w(NUM_FRAMES)-1:0] frame_select,
  input  logic                        busy,
  output logic                        kick,
  output logic [ADDR_W-1:0]           read_addr,
  output logic [31:0]                 read_num,
  output logic                        active,
  output logic                        frame_done,
  output logic                        sel_err
);

  localparam int unsigned FS_W = fs_w(NUM_FRAMES);

  // Elaboration-time geometry checks.
  if ((NUM_FRAMES < 1) || (NUM_FRAMES > 16)) begin : g_bad_num_frames
    $error("NUM_FRAMES must be 1..16");
  end
  if (((X_SIZE * Y_SIZE) % BURST_WORDS) != 0) begin : g_bad_burst
    $error("frame size must be a multiple of BURST_WORDS");
  end
  if ((LINE_PITCH % BYTES_PER_PIXEL) != 0) begin : g_bad_pitch
    $error("LINE_PITCH must be a whole number of pixels");
  end

  logic [ST_W-1:0]   state_q, state_d;
  logic [FS_W-1:0]   frame_q, frame_d;
  logic              sel_err_q, sel_err_d;
  logic              kick_q, kick_d;
  logic              active_q, active_d;
  logic              frame_done_q, frame_done_d;
  logic [ADDR_W-1:0] read_addr_q, read_addr_d;
  logic              cnt_clear, cnt_advance;
  logic [ADDR_W-1:0] offset;
  logic              last_burst;

  hdmi_rd_offset_cnt #(
    .X_SIZE          (X_SIZE),
    .Y_SIZE          (Y_SIZE),
    .BYTES_PER_PIXEL (BYTES_PER_PIXEL),
    .BURST_WORDS     (BURST_WORDS)
`ifdef HDMI_RD_LINE_PITCH_EN
    ,
    .LINE_PITCH      (LINE_PITCH)
`endif
  ) u_offset_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .offset  (offset),
    .last    (last_burst)
  );

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    sel_err_d   = sel_err_q;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clear = 1'b1;
        if (32'(frame_select) >= NUM_FRAMES) begin
          frame_d   = '0;
          sel_err_d = 1'b1;
        end else begin
          frame_d = frame_select;
        end
        if (prefetch_line) state_d = ST_ISSUE_IDLE;
      end
      ST_ISSUE_IDLE: if (!busy) state_d = ST_ISSUE;
      ST_ISSUE:      state_d = ST_ISSUE_WAIT;
      ST_ISSUE_WAIT: begin
        if (busy) begin
          cnt_advance = 1'b1;
          state_d     = last_burst ? ST_IDLE : ST_NEXT_IDLE;
        end
      end
      ST_NEXT_IDLE:  if (fifo_available < FIFO_LOW_WM) state_d = ST_ISSUE_IDLE;
      default:       state_d = ST_IDLE;
    endcase
    kick_d       = (state_d == ST_ISSUE) || (state_d == ST_ISSUE_WAIT);
    active_d     = (state_d != ST_IDLE);
    frame_done_d = cnt_advance && last_burst;
    // Built from registered frame/offset only; settles well before the next ISSUE.
    read_addr_d  = BASE_ADDR + FRAME_STRIDE * 32'(frame_q) + offset;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      frame_q      <= '0;
      sel_err_q    <= 1'b0;
      kick_q       <= 1'b0;
      active_q     <= 1'b0;
      frame_done_q <= 1'b0;
      read_addr_q  <= BASE_ADDR;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      sel_err_q    <= sel_err_d;
      kick_q       <= kick_d;
      active_q     <= active_d;
      frame_done_q <= frame_done_d;
      read_addr_q  <= read_addr_d;
    end
  end

  assign kick       = kick_q;
  assign active     = active_q;
  assign frame_done = frame_done_q;
  assign sel_err    = sel_err_q;
  assign read_addr  = read_addr_q;
  assign read_num   = 32'(BURST_WORDS);

endmodule

// File: doc/hdmi_frame_rd_addr.md
# hdmi_frame_rd_addr

Parametrised read-address generator for the HDMI scan-out path. It issues fixed-length AXI read bursts covering one frame buffer out of an N-entry ring, and throttles issue against the pixel FIFO fill level. It sits between the HDMI timing/prefetch logic and the AXI read master (kick/busy handshake). It generalises the two-buffer generator with configurable pixel size, burst length, buffer count, base/stride, and an optional line pitch.

## Interface
Parameters:
- X_SIZE, 256, active pixels per line
- Y_SIZE, 256, active lines per frame
- BYTES_PER_PIXEL, 4, bytes per pixel word (1 word = 1 pixel)
- BURST_WORDS, 256, words per read burst; X_SIZE*Y_SIZE must be a multiple of it (pitch mode: X_SIZE must be a multiple of it)
- NUM_FRAMES, 2, frame buffers in the ring, 1..16
- BASE_ADDR, 32'h0, byte address of frame 0
- FRAME_STRIDE, 32'h200_0000, byte distance between frame buffers
- LINE_PITCH, X_SIZE*BYTES_PER_PIXEL, byte distance between lines (pitch mode only)
- FIFO_LOW_WM, 6400, next burst may issue only when fifo_available < FIFO_LOW_WM

Ports (FS_W = max(1, clog2(NUM_FRAMES))):
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- prefetch_line  in  1  frame start request; honoured only in IDLE
- fifo_available  in  32  current pixel FIFO fill (words)
- frame_select  in  FS_W  buffer index to read; sampled every IDLE cycle
- busy  in  1  read master busy / burst accepted
- kick  out  1  burst request
- read_addr  out  32  byte address of the current burst
- read_num  out  32  burst length in words, constant BURST_WORDS
- active  out  1  high whenever state != IDLE
- frame_done  out  1  one-cycle pulse when the last burst of a frame is accepted
- sel_err  out  1  sticky flag: frame_select >= NUM_FRAMES was captured; cleared only by rst

## Operation
- States: IDLE, ISSUE_IDLE, ISSUE, ISSUE_WAIT, NEXT_IDLE.
- IDLE -> ISSUE_IDLE on prefetch_line.
- ISSUE_IDLE -> ISSUE when busy==0.
- ISSUE -> ISSUE_WAIT unconditionally.
- ISSUE_WAIT, busy==1 (acceptance): advance offset. Last burst -> IDLE and pulse frame_done. Otherwise -> NEXT_IDLE.
- NEXT_IDLE -> ISSUE_IDLE when fifo_available < FIFO_LOW_WM.
- kick = (state==ISSUE || state==ISSUE_WAIT).
- In IDLE: frame register loads frame_select. If frame_select >= NUM_FRAMES, load 0 and set sel_err. Offset counters clear.
- read_addr = BASE_ADDR + frame_reg*FRAME_STRIDE + offset, computed mod 2^32.
- Offset without pitch: burst_idx*BURST_WORDS*BYTES_PER_PIXEL, with burst_idx in 0..X_SIZE*Y_SIZE/BURST_WORDS-1.
- read_addr depends on registers only. It is stable from ISSUE until the acceptance cycle.
- prefetch_line outside IDLE is ignored; there is no re-arm.
- frame_select changes outside IDLE have no effect until the next IDLE.

## Timing
- Reset values:
  - state IDLE, kick 0, active 0, frame_done 0, sel_err 0.
  - frame_reg 0, offsets 0, so read_addr = BASE_ADDR.
  - read_num = BURST_WORDS at all times.
- Async reset mid-frame: kick and active drop immediately, with no completion pulse.
- Latency with busy low and the FIFO below the watermark:
  - prefetch_line at cycle n -> kick high at n+2.
  - Acceptance at cycle m -> next kick at m+3.
- busy already high in ISSUE_WAIT on entry counts as acceptance at that cycle.
- frame_done is asserted in the cycle after acceptance of the last burst, coincident with state==IDLE.

## Configuration
- HDMI_RD_LINE_PITCH_EN defined:
  - Two counters: burst-in-line (0..X_SIZE/BURST_WORDS-1) and line (0..Y_SIZE-1).
  - offset = line*LINE_PITCH + burst_in_line*BURST_WORDS*BYTES_PER_PIXEL.
  - On the last burst of a line, burst-in-line wraps to 0 and line increments.
  - The frame ends at line Y_SIZE-1, last burst.
- Undefined: single linear burst counter, LINE_PITCH ignored, contiguous frame.

## Structure
- Package hdmi_rd_pkg holds:
  - state enum
  - derived constants: BURSTS_PER_LINE, BURSTS_PER_FRAME, BURST_BYTES
  - FS_W function
- One sub-module, hdmi_rd_offset_cnt:
  - Inputs: clear, advance.
  - Outputs: offset, last (last-burst flag).
  - Holds the linear or pitch counter selected by the macro.
- Top level holds the FSM, frame register and address adder.

## Test plan
- Defaults, busy pulses one cycle after each kick, fifo_available=0 -> 256 bursts at 0x0, 0x400, … 0x3FC00; one frame_done; returns to IDLE.
- frame_select=1 at prefetch, changed to 0 mid-frame -> all addresses in 0x200_0000..0x203_FC00.
- fifo_available=6400 held in NEXT_IDLE -> no kick; drop to 6399 -> kick 2 cycles later.
- NUM_FRAMES=3, frame_select=3 -> frame 0 addresses, sel_err=1 until rst.
- HDMI_RD_LINE_PITCH_EN, X_SIZE=512, BURST_WORDS=256, LINE_PITCH=4096 -> addresses 0x0, 0x400, 0x1000, 0x1400, …
- rst asserted while in ISSUE_WAIT -> kick 0 immediately; next prefetch_line restarts at BASE_ADDR.
